// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
//   REG_W        : architectural register index width
//   FWD_*        : ALU operand source encodings used by the EX stage muxes
//   sb_entry_t   : one shadow-scoreboard slot {valid, rd, is_load}
package pipeline_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, rd: '0, is_load: 1'b0};

endpackage

// File: rtl/rd_match.sv
// Combinational producer/consumer compare between one scoreboard slot and
// one ID-stage source operand.
//   entry    : scoreboard slot under test
//   rs       : ID source register index
//   uses     : ID instruction actually reads rs
//   id_valid : ID holds a real instruction
//   match    : the slot produces the value this source needs
module rd_match
  import pipeline_pkg::*;
(
  input  sb_entry_t        entry,
  input  logic [REG_W-1:0] rs,
  input  logic             uses,
  input  logic             id_valid,
  output logic             match
);

  // The load flag matters only to the load-use detector in the parent.
  logic unused_is_load;
  assign unused_is_load = entry.is_load;

  // x0 is hard-wired zero, so it is never a real dependency even if a stale
  // entry were to carry rd=0.
  assign match = entry.valid && uses && id_valid &&
                 (rs != '0) && (rs == entry.rd);

endmodule

// File: rtl/pipeline_scheduler.sv
// Hazard and sequencing controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Tracks destination registers in flight in EX, MEM and WB, generates
// stall / bubble / flush controls, registers ALU forwarding selects for the
// instruction entering EX, and counts stall cycles.
//   clk, reset                : clock, synchronous active-high reset
//   id_*                      : decoded info of the instruction in ID
//   ex_branch_taken           : taken branch/jump resolved in EX this cycle
//   mem_busy                  : data memory not ready, freeze everything
//   pc_stall, if_id_stall     : hold PC and IF/ID
//   id_ex_bubble, if_id_flush : inject NOPs into ID/EX and IF/ID
//   fwd_rs1, fwd_rs2          : EX operand source selects (registered)
//   stall_count               : saturating count of pc_stall cycles
module pipeline_scheduler #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_writes_rd,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic [1:0]       fwd_rs1,
  output logic [1:0]       fwd_rs2,
  output logic [CNT_W-1:0] stall_count
);

  pipeline_pkg::sb_entry_t sb_ex_q, sb_ex_d;
  pipeline_pkg::sb_entry_t sb_mem_q, sb_mem_d;
  pipeline_pkg::sb_entry_t sb_wb_q, sb_wb_d;

  logic [1:0]       fwd_rs1_q, fwd_rs1_d;
  logic [1:0]       fwd_rs2_q, fwd_rs2_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic m_rs1_ex, m_rs2_ex, m_rs1_mem, m_rs2_mem, m_rs1_wb, m_rs2_wb;
  logic load_use;

  rd_match u_m_rs1_ex (.entry(sb_ex_q), .rs(id_rs1), .uses(id_uses_rs1),
                       .id_valid(id_valid), .match(m_rs1_ex));
  rd_match u_m_rs2_ex (.entry(sb_ex_q), .rs(id_rs2), .uses(id_uses_rs2),
                       .id_valid(id_valid), .match(m_rs2_ex));
  rd_match u_m_rs1_mem (.entry(sb_mem_q), .rs(id_rs1), .uses(id_uses_rs1),
                        .id_valid(id_valid), .match(m_rs1_mem));
  rd_match u_m_rs2_mem (.entry(sb_mem_q), .rs(id_rs2), .uses(id_uses_rs2),
                        .id_valid(id_valid), .match(m_rs2_mem));
  rd_match u_m_rs1_wb (.entry(sb_wb_q), .rs(id_rs1), .uses(id_uses_rs1),
                       .id_valid(id_valid), .match(m_rs1_wb));
  rd_match u_m_rs2_wb (.entry(sb_wb_q), .rs(id_rs2), .uses(id_uses_rs2),
                       .id_valid(id_valid), .match(m_rs2_wb));

  // A WB producer is visible through the register file (write-first), so
  // these compares need no forwarding path.
  logic unused_wb_match;
  assign unused_wb_match = m_rs1_wb ^ m_rs2_wb;

  // Only a load sitting in EX cannot forward in time; one stall moves it to
  // MEM where the MEM/WB path covers the consumer.
  assign load_use = sb_ex_q.is_load && (m_rs1_ex || m_rs2_ex);

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (mem_busy) begin
      // Freeze wins; a taken branch stays latched in the datapath.
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
    end else if (ex_branch_taken) begin
      // ID is squashed, so any load-use hazard it carried is moot.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  always_comb begin
    sb_ex_d       = sb_ex_q;
    sb_mem_d      = sb_mem_q;
    sb_wb_d       = sb_wb_q;
    fwd_rs1_d     = fwd_rs1_q;
    fwd_rs2_d     = fwd_rs2_q;
    stall_count_d = stall_count_q;

    if (pc_stall && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end

    if (!mem_busy) begin
      sb_wb_d  = sb_mem_q;
      sb_mem_d = sb_ex_q;

      if (id_ex_bubble || !id_valid) begin
        sb_ex_d = pipeline_pkg::SB_EMPTY;
      end else begin
        sb_ex_d.valid   = id_writes_rd && (id_rd != '0);
        sb_ex_d.rd      = id_rd;
        sb_ex_d.is_load = id_is_load;
      end

      // Selects are computed against the pre-advance slots: what is in EX
      // now will be in EX/MEM when this instruction reaches EX.
      if (id_ex_bubble) begin
        fwd_rs1_d = pipeline_pkg::FWD_RF;
        fwd_rs2_d = pipeline_pkg::FWD_RF;
      end else begin
        fwd_rs1_d = m_rs1_ex  ? pipeline_pkg::FWD_EXMEM :
                    m_rs1_mem ? pipeline_pkg::FWD_MEMWB : pipeline_pkg::FWD_RF;
        fwd_rs2_d = m_rs2_ex  ? pipeline_pkg::FWD_EXMEM :
                    m_rs2_mem ? pipeline_pkg::FWD_MEMWB : pipeline_pkg::FWD_RF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_ex_q       <= pipeline_pkg::SB_EMPTY;
      sb_mem_q      <= pipeline_pkg::SB_EMPTY;
      sb_wb_q       <= pipeline_pkg::SB_EMPTY;
      fwd_rs1_q     <= pipeline_pkg::FWD_RF;
      fwd_rs2_q     <= pipeline_pkg::FWD_RF;
      stall_count_q <= '0;
    end else begin
      sb_ex_q       <= sb_ex_d;
      sb_mem_q      <= sb_mem_d;
      sb_wb_q       <= sb_wb_d;
      fwd_rs1_q     <= fwd_rs1_d;
      fwd_rs2_q     <= fwd_rs2_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fwd_rs1     = fwd_rs1_q;
  assign fwd_rs2     = fwd_rs2_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_scheduler.sv
module tb_pipeline_scheduler;

  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_uses_rs1, id_uses_rs2, id_writes_rd, id_is_load;
  logic          ex_branch_taken, mem_busy;
  logic          pc_stall, if_id_stall, id_ex_bubble, if_id_flush;
  logic [1:0]    fwd_rs1, fwd_rs2;
  logic [CW-1:0] stall_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_scheduler #(.REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_writes_rd(id_writes_rd), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .stall_count(stall_count)
  );

  // Reference model: a list of instructions issued past ID, youngest first
  // (element 0 is the one now in EX, 1 in MEM, 2 in WB).
  typedef struct {
    bit w;
    int rd;
    bit ld;
  } mi_t;

  mi_t pipe[$];
  int  m_f1, m_f2, m_cnt;
  bit  e_pc, e_ifs, e_bub, e_flush;

  function automatic bit needs(mi_t e, int rs, bit u);
    return id_valid && u && e.w && (e.rd != 0) && (e.rd == rs);
  endfunction

  function automatic void model_reset();
    mi_t none;
    none = '{w: 0, rd: 0, ld: 0};
    pipe = {};
    for (int k = 0; k < 3; k++) pipe.push_back(none);
    m_f1  = 0;
    m_f2  = 0;
    m_cnt = 0;
  endfunction

  function automatic void model_ctrl();
    bit lu;
    lu = pipe[0].ld && (needs(pipe[0], int'(id_rs1), id_uses_rs1) ||
                        needs(pipe[0], int'(id_rs2), id_uses_rs2));
    e_pc    = mem_busy || (!ex_branch_taken && lu);
    e_ifs   = e_pc;
    e_bub   = !mem_busy && (ex_branch_taken || lu);
    e_flush = !mem_busy && ex_branch_taken;
  endfunction

  function automatic int pick(int rs, bit u);
    if (needs(pipe[0], rs, u)) return 1;
    if (needs(pipe[1], rs, u)) return 2;
    return 0;
  endfunction

  function automatic void model_edge();
    mi_t nxt;
    if (reset) begin
      model_reset();
      return;
    end
    if (e_pc && m_cnt < (1 << CW) - 1) m_cnt++;
    if (!mem_busy) begin
      m_f1 = e_bub ? 0 : pick(int'(id_rs1), id_uses_rs1);
      m_f2 = e_bub ? 0 : pick(int'(id_rs2), id_uses_rs2);
      if (e_bub || !id_valid) nxt = '{w: 0, rd: 0, ld: 0};
      else nxt = '{w: id_writes_rd, rd: int'(id_rd), ld: id_is_load};
      pipe.push_front(nxt);
      void'(pipe.pop_back());
    end
  endfunction

  task automatic set_id(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit w, bit ld);
    id_valid     = v;
    id_rs1       = RW'(rs1);
    id_uses_rs1  = u1;
    id_rs2       = RW'(rs2);
    id_uses_rs2  = u2;
    id_rd        = RW'(rd);
    id_writes_rd = w;
    id_is_load   = ld;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    #1;
    model_ctrl();
  endtask

  task automatic advance();
    #1;
    model_ctrl();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ex_branch_taken = 1'b0;
    mem_busy = 1'b0;
    idle();
    advance();
    advance();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    total++;
    if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=0000", {pc_stall, if_id_stall, id_ex_bubble, if_id_flush});
    end
    total++;
    if ({fwd_rs1, fwd_rs2} !== 4'b0000 || stall_count !== '0) begin
      bad++;
      $display("FAIL reset_state fwd=%b cnt=%0d want fwd=0000 cnt=0", {fwd_rs1, fwd_rs2}, stall_count);
    end
  endtask

  task automatic test_alu_chain();
    do_reset();
    set_id(1, 1, 1, 2, 1, 5, 1, 0);
    advance();
    set_id(1, 5, 1, 5, 1, 6, 1, 0);
    settle();
    total++;
    if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush} !== 4'b0000) begin
      bad++;
      $display("FAIL chain_nostall got=%b want=0000", {pc_stall, if_id_stall, id_ex_bubble, if_id_flush});
    end
    advance();
    idle();
    total++;
    if ({fwd_rs1, fwd_rs2} !== 4'b0101) begin
      bad++;
      $display("FAIL chain_fwd got=%b want=0101", {fwd_rs1, fwd_rs2});
    end
  endtask

  task automatic test_distance2();
    do_reset();
    set_id(1, 1, 1, 2, 1, 5, 1, 0);
    advance();
    idle();
    advance();
    set_id(1, 5, 1, 1, 1, 7, 1, 0);
    advance();
    idle();
    total++;
    if ({fwd_rs1, fwd_rs2} !== 4'b1000) begin
      bad++;
      $display("FAIL dist2_fwd got=%b want=1000", {fwd_rs1, fwd_rs2});
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 2, 1, 0, 0, 8, 1, 1);
    advance();
    set_id(1, 8, 1, 0, 1, 9, 1, 0);
    settle();
    total++;
    if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush} !== 4'b1110) begin
      bad++;
      $display("FAIL lu_stall got=%b want=1110", {pc_stall, if_id_stall, id_ex_bubble, if_id_flush});
    end
    advance();
    total++;
    if ({fwd_rs1, fwd_rs2} !== 4'b0000 || stall_count !== 4'd1) begin
      bad++;
      $display("FAIL lu_bubble fwd=%b cnt=%0d want fwd=0000 cnt=1", {fwd_rs1, fwd_rs2}, stall_count);
    end
    settle();
    total++;
    if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush} !== 4'b0000) begin
      bad++;
      $display("FAIL lu_oneshot got=%b want=0000", {pc_stall, if_id_stall, id_ex_bubble, if_id_flush});
    end
    advance();
    idle();
    total++;
    if ({fwd_rs1, fwd_rs2} !== 4'b1000 || stall_count !== 4'd1) begin
      bad++;
      $display("FAIL lu_fwd fwd=%b cnt=%0d want fwd=1000 cnt=1", {fwd_rs1, fwd_rs2}, stall_count);
    end
  endtask

  task automatic test_branch_flush();
    do_reset();
    set_id(1, 2, 1, 0, 0, 8, 1, 1);
    advance();
    set_id(1, 8, 1, 0, 1, 9, 1, 0);
    ex_branch_taken = 1'b1;
    settle();
    total++;
    if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush} !== 4'b0011) begin
      bad++;
      $display("FAIL br_flush got=%b want=0011", {pc_stall, if_id_stall, id_ex_bubble, if_id_flush});
    end
    advance();
    ex_branch_taken = 1'b0;
    idle();
    total++;
    if ({fwd_rs1, fwd_rs2} !== 4'b0000 || stall_count !== 4'd0) begin
      bad++;
      $display("FAIL br_after fwd=%b cnt=%0d want fwd=0000 cnt=0", {fwd_rs1, fwd_rs2}, stall_count);
    end
  endtask

  task automatic test_mem_busy();
    do_reset();
    set_id(1, 1, 1, 2, 1, 4, 1, 0);
    advance();
    set_id(1, 4, 1, 1, 1, 5, 1, 0);
    advance();
    set_id(1, 5, 1, 5, 1, 6, 1, 0);
    mem_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      total++;
      if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush} !== 4'b1100) begin
        bad++;
        $display("FAIL busy_ctl[%0d] got=%b want=1100", c, {pc_stall, if_id_stall, id_ex_bubble, if_id_flush});
      end
      advance();
      total++;
      if ({fwd_rs1, fwd_rs2} !== 4'b0100) begin
        bad++;
        $display("FAIL busy_fwd_hold[%0d] got=%b want=0100", c, {fwd_rs1, fwd_rs2});
      end
    end
    mem_busy = 1'b0;
    advance();
    total++;
    if ({fwd_rs1, fwd_rs2} !== 4'b0101 || stall_count !== 4'd3) begin
      bad++;
      $display("FAIL busy_resume fwd=%b cnt=%0d want fwd=0101 cnt=3", {fwd_rs1, fwd_rs2}, stall_count);
    end
    set_id(1, 5, 1, 6, 1, 7, 1, 0);
    advance();
    idle();
    total++;
    if ({fwd_rs1, fwd_rs2} !== 4'b1001) begin
      bad++;
      $display("FAIL busy_sb_kept got=%b want=1001", {fwd_rs1, fwd_rs2});
    end
  endtask

  task automatic test_saturate();
    do_reset();
    mem_busy = 1'b1;
    for (int c = 0; c < 20; c++) advance();
    mem_busy = 1'b0;
    total++;
    if (stall_count !== 4'hF) begin
      bad++;
      $display("FAIL cnt_saturate got=%0d want=15", stall_count);
    end
  endtask

  task automatic test_x0_and_reset();
    do_reset();
    set_id(1, 1, 1, 2, 1, 0, 1, 0);
    advance();
    set_id(1, 0, 1, 0, 1, 1, 1, 0);
    settle();
    total++;
    if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush} !== 4'b0000) begin
      bad++;
      $display("FAIL x0_nostall got=%b want=0000", {pc_stall, if_id_stall, id_ex_bubble, if_id_flush});
    end
    advance();
    total++;
    if ({fwd_rs1, fwd_rs2} !== 4'b0000) begin
      bad++;
      $display("FAIL x0_fwd got=%b want=0000", {fwd_rs1, fwd_rs2});
    end
    set_id(1, 2, 1, 0, 0, 8, 1, 1);
    advance();
    set_id(1, 8, 1, 0, 0, 9, 1, 0);
    reset = 1'b1;
    advance();
    reset = 1'b0;
    settle();
    total++;
    if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush, fwd_rs1, fwd_rs2} !== 8'h00 ||
        stall_count !== 4'd0) begin
      bad++;
      $display("FAIL midreset ctl_fwd=%b cnt=%0d want 00000000 cnt=0",
               {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, fwd_rs1, fwd_rs2}, stall_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset           = ($urandom_range(63) == 0);
      mem_busy        = ($urandom_range(5) == 0);
      ex_branch_taken = ($urandom_range(7) == 0);
      set_id($urandom_range(7) != 0, $urandom_range(3), $urandom_range(1),
             $urandom_range(3), $urandom_range(1), $urandom_range(3),
             $urandom_range(3) != 0, $urandom_range(2) == 0);
      settle();
      total++;
      if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush} !== {e_pc, e_ifs, e_bub, e_flush}) begin
        bad++;
        $display("FAIL rand_ctl[%0d] got=%b want=%b", c,
                 {pc_stall, if_id_stall, id_ex_bubble, if_id_flush}, {e_pc, e_ifs, e_bub, e_flush});
      end
      advance();
      total++;
      if (fwd_rs1 !== 2'(m_f1) || fwd_rs2 !== 2'(m_f2) || stall_count !== CW'(m_cnt)) begin
        bad++;
        $display("FAIL rand_state[%0d] fwd=%b%b cnt=%0d want fwd=%b%b cnt=%0d", c,
                 fwd_rs1, fwd_rs2, stall_count, 2'(m_f1), 2'(m_f2), m_cnt);
      end
    end
    reset = 1'b0;
    mem_busy = 1'b0;
    ex_branch_taken = 1'b0;
    idle();
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    mem_busy = 1'b0;
    ex_branch_taken = 1'b0;
    idle();
    test_reset();
    test_alu_chain();
    test_distance2();
    test_load_use();
    test_branch_flush();
    test_mem_busy();
    test_saturate();
    test_x0_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
